// File: rtl/lif_net_pkg.sv
// Shared constants and helpers for the LIF oscillator network.
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
package lif_net_pkg;

  // Weights occupy the bottom of the config space, row-major by source neuron.
  function automatic int weight_base();
    return 0;
  endfunction

  // Bias registers follow the n*n weight block.
  function automatic int bias_base(input int n);
    return n * n;
  endfunction

  // Signed accumulator width that holds v + bias + n-1 weights without overflow.
  function automatic int acc_width(input int vw, input int ww, input int n);
    return vw + ww + $clog2(n) + 2;
  endfunction

  // Saturate x into [lo, hi].
  function automatic int clamp_int(input int x, input int lo, input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron with threshold, clamp and refractory counter.
// Latency: spike and potential register one enabled edge after the inputs are presented.
// Backpressure: none; enable low freezes all state.
module lif_neuron
  import lif_net_pkg::*;
#(
  parameter int V_WIDTH    = 8,
  parameter int ACC_W      = 20,
  parameter int THRESHOLD  = 200,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [V_WIDTH-1:0]      bias,
  input  logic signed [ACC_W-1:0] syn_sum,
  output logic [V_WIDTH-1:0]      v,
  output logic                    spike,
  output logic                    spike_nxt
);

  localparam int R_W   = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam int V_MAX = (1 << V_WIDTH) - 1;

  logic [R_W-1:0]          r;
  logic [R_W-1:0]          r_nxt;
  logic [V_WIDTH-1:0]      v_nxt;
  logic signed [ACC_W-1:0] acc;

  // Next-state: refractory hold, fire-and-reset, or leaky integration with clamp.
  always_comb begin
    acc       = $signed(ACC_W'(v)) - $signed(ACC_W'(v >> LEAK_SHIFT))
              + $signed(ACC_W'(bias)) + syn_sum;
    v_nxt     = v;
    r_nxt     = r;
    spike_nxt = 1'b0;
    if (r != '0) begin
      v_nxt = '0;
      r_nxt = r - R_W'(1);
    end else if (acc >= $signed(ACC_W'(THRESHOLD))) begin
      v_nxt     = '0;
      r_nxt     = R_W'(REFRACT);
      spike_nxt = 1'b1;
    end else begin
      v_nxt = V_WIDTH'(clamp_int(int'(acc), 0, V_MAX));
    end
  end

  // State register; advances only on enabled edges, reset wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      v     <= '0;
      r     <= '0;
      spike <= 1'b0;
    end else if (enable) begin
      v     <= v_nxt;
      r     <= r_nxt;
      spike <= spike_nxt;
    end
  end

endmodule

// File: rtl/lif_oscillator_network.sv
// N coupled LIF neurons with byte-wide config of weights/biases and spike/membrane monitors.
// Latency: spikes register one edge after integration; a spike couples into targets on the next edge.
// Backpressure: none; enable low freezes neurons and the spike counter, config writes still land.
module lif_oscillator_network
  import lif_net_pkg::*;
#(
  parameter int N_NEURONS  = 4,
  parameter int V_WIDTH    = 8,
  parameter int W_WIDTH    = 8,
  parameter int THRESHOLD  = 200,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 4,
  parameter int BIAS_INIT  = 0
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 enable,
  input  logic                                                 cfg_we,
  input  logic [$clog2(N_NEURONS*N_NEURONS+N_NEURONS)-1:0]     cfg_addr,
  input  logic [7:0]                                           cfg_data,
  input  logic [$clog2(N_NEURONS)-1:0]                         mon_sel,
  output logic [N_NEURONS-1:0]                                 spike_out,
  output logic                                                 spike_any,
  output logic [7:0]                                           spike_count,
  output logic [V_WIDTH-1:0]                                   mon_v
);

  localparam int ACC_W  = acc_width(V_WIDTH, W_WIDTH, N_NEURONS);
  localparam int W_BASE = weight_base();
  localparam int B_BASE = bias_base(N_NEURONS);

  logic signed [W_WIDTH-1:0] w    [N_NEURONS][N_NEURONS];
  logic [V_WIDTH-1:0]        bias [N_NEURONS];
  logic signed [ACC_W-1:0]   syn  [N_NEURONS];
  logic [V_WIDTH-1:0]        v    [N_NEURONS];
  logic [N_NEURONS-1:0]      spike_nxt;

  // Config register file: address decode into weight matrix and bias vector; unmapped addresses drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < N_NEURONS; s++) begin
        for (int d = 0; d < N_NEURONS; d++) w[s][d] <= '0;
        bias[s] <= V_WIDTH'(BIAS_INIT);
      end
    end else if (cfg_we) begin
      for (int s = 0; s < N_NEURONS; s++) begin
        for (int d = 0; d < N_NEURONS; d++) begin
          if (int'(cfg_addr) == W_BASE + s * N_NEURONS + d) w[s][d] <= cfg_data[W_WIDTH-1:0];
        end
        if (int'(cfg_addr) == B_BASE + s) bias[s] <= cfg_data[V_WIDTH-1:0];
      end
    end
  end

  // Synaptic sum per target from last edge's spikes; self-weights are skipped.
  always_comb begin
    for (int i = 0; i < N_NEURONS; i++) begin
      syn[i] = '0;
      for (int j = 0; j < N_NEURONS; j++) begin
        if (j != i && spike_out[j]) syn[i] = syn[i] + ACC_W'(w[j][i]);
      end
    end
  end

  for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
    lif_neuron #(
      .V_WIDTH    (V_WIDTH),
      .ACC_W      (ACC_W),
      .THRESHOLD  (THRESHOLD),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REFRACT    (REFRACT)
    ) u_neuron (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .bias      (bias[gi]),
      .syn_sum   (syn[gi]),
      .v         (v[gi]),
      .spike     (spike_out[gi]),
      .spike_nxt (spike_nxt[gi])
    );
  end

  // Aggregate spike flag and saturating count of spiking edges, aligned with spike_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      spike_any   <= 1'b0;
      spike_count <= '0;
    end else if (enable) begin
      spike_any <= |spike_nxt;
      if ((|spike_nxt) && spike_count != 8'hFF) spike_count <= spike_count + 8'd1;
    end
  end

  assign mon_v = v[mon_sel];

endmodule

// File: tb/tb_lif_oscillator_network.sv
module tb_lif_oscillator_network;

  localparam int N    = 4;
  localparam int TH   = 200;
  localparam int LEAK = 3;
  localparam int REF  = 4;
  localparam int VMAX = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       cfg_we;
  logic [4:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [1:0] mon_sel;
  logic [3:0] spike_out;
  logic       spike_any;
  logic [7:0] spike_count;
  logic [7:0] mon_v;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model state
  int mv [N];
  int mr [N];
  int ms [N];
  int mb [N];
  int mw [N][N];
  int mcnt;
  int many;

  always #5 clk = ~clk;

  lif_oscillator_network dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .mon_sel     (mon_sel),
    .spike_out   (spike_out),
    .spike_any   (spike_any),
    .spike_count (spike_count),
    .mon_v       (mon_v)
  );

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // One edge of the network computed from the rules with plain integer arithmetic.
  task automatic model_step();
    int nv [N];
    int nr [N];
    int ns [N];
    int acc;
    int fired;
    int a;
    logic signed [7:0] sd;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mv[i] = 0; mr[i] = 0; ms[i] = 0; mb[i] = 0;
        for (int j = 0; j < N; j++) mw[i][j] = 0;
      end
      mcnt = 0;
      many = 0;
      return;
    end
    if (enable) begin
      fired = 0;
      for (int i = 0; i < N; i++) begin
        if (mr[i] > 0) begin
          nv[i] = 0; nr[i] = mr[i] - 1; ns[i] = 0;
        end else begin
          acc = mv[i] - mv[i] / (2 ** LEAK) + mb[i];
          for (int j = 0; j < N; j++) if (j != i && ms[j] != 0) acc += mw[j][i];
          if (acc >= TH) begin
            nv[i] = 0; nr[i] = REF; ns[i] = 1;
          end else begin
            nv[i] = (acc < 0) ? 0 : (acc > VMAX) ? VMAX : acc;
            nr[i] = 0; ns[i] = 0;
          end
        end
        if (ns[i] != 0) fired = 1;
      end
      for (int i = 0; i < N; i++) begin
        mv[i] = nv[i]; mr[i] = nr[i]; ms[i] = ns[i];
      end
      many = fired;
      if (fired != 0 && mcnt < 255) mcnt++;
    end
    if (cfg_we) begin
      a  = int'(cfg_addr);
      sd = cfg_data;
      if (a < N * N) mw[a / N][a % N] = int'(sd);
      else if (a < N * N + N) mb[a - N * N] = int'(cfg_data);
    end
  endtask

  task automatic check_all();
    int sv;
    sv = 0;
    for (int i = 0; i < N; i++) sv |= ms[i] << i;
    chk("spike_out", spike_out, sv);
    chk("spike_any", spike_any, many);
    chk("spike_count", spike_count, mcnt);
    for (int k = 0; k < N; k++) begin
      mon_sel = 2'(k);
      #1;
      chk($sformatf("mon_v[%0d]", k), mon_v, mv[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check_all();
  endtask

  task automatic write_cfg(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = 5'(a);
    cfg_data = 8'(d);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int seq [7];
    seq = '{40, 75, 106, 133, 157, 178, 196};
    reset = 1'b1; enable = 1'b1; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0; mon_sel = '0;

    // reset with enable high and config writes that must be ignored
    for (int k = 0; k < 3; k++) begin
      cfg_we   = 1'b1;
      cfg_addr = 5'($urandom_range(0, 19));
      cfg_data = 8'($urandom);
      tick();
    end
    cfg_we = 1'b0;
    reset  = 1'b0;

    // bias-driven oscillation of neuron 0
    enable = 1'b0;
    write_cfg(16, 40);
    enable = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (e <= 7) begin
        mon_sel = 2'd0;
        #1;
        chk("v0_ramp", mon_v, seq[e-1]);
      end
      if (e == 8) chk("first_spike0", spike_out[0], 1);
    end
    chk("count_after_32", spike_count, 3);

    // excitatory coupling 0 -> 1 lands exactly one edge after the spike
    do_reset();
    enable = 1'b0;
    write_cfg(16, 40);
    write_cfg(1, 127);
    enable = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == 9) begin
        mon_sel = 2'd1;
        #1;
        chk("w01_hit", mon_v, 127);
      end
    end

    // inhibitory coupling clamps neuron 1 at zero, then a freeze
    do_reset();
    enable = 1'b0;
    write_cfg(1, 8'h80);
    write_cfg(16, 40);
    write_cfg(17, 50);
    enable = 1'b1;
    write_cfg(17, 0);
    for (int e = 2; e <= 12; e++) begin
      tick();
      if (e == 9) begin
        mon_sel = 2'd1;
        #1;
        chk("inhib_clamp", mon_v, 0);
      end
    end
    enable = 1'b0;
    for (int e = 0; e < 5; e++) tick();
    enable = 1'b1;
    for (int e = 0; e < 20; e++) tick();

    // randomized traffic: config writes (including unmapped), enable gaps, rare resets
    for (int c = 0; c < 2000; c++) begin
      enable   = ($urandom_range(0, 9) != 0);
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_addr = 5'($urandom_range(0, 31));
      cfg_data = 8'($urandom);
      reset    = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; cfg_we = 1'b0;

    // counter saturation with all biases at full scale
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < N; i++) write_cfg(16 + i, 255);
    enable = 1'b1;
    for (int e = 0; e < 1300; e++) tick();
    chk("count_sat", spike_count, 255);
    write_cfg(20, $urandom_range(0, 255));
    for (int e = 0; e < 10; e++) tick();
    chk("count_sat_hold", spike_count, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lif_oscillator_network.md
Name: lif_oscillator_network

Overview:
Parametrised network of N leaky integrate-and-fire neurons with a programmable all-to-all signed coupling matrix, per-neuron bias drive and refractory period. It succeeds the fixed two-neuron/two-synapse top, where spikes only OR'ed to one pin and had no coupling. Sits under the tt_um top; configured through a byte-wide write port and observed via spike vector, aggregate spike pulse, saturating spike counter and membrane monitor.

Parameters:
N_NEURONS, 4, neuron count (2..8)
V_WIDTH, 8, membrane potential width, unsigned
W_WIDTH, 8, coupling weight width, two's-complement signed
THRESHOLD, 200, fire when updated potential >= THRESHOLD (must be <= 2^V_WIDTH-1)
LEAK_SHIFT, 3, leak = v >> LEAK_SHIFT per enabled cycle
REFRACT, 4, refractory cycles after a spike (0 = none)
BIAS_INIT, 0, reset value of every bias register

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  network advances only when high; low freezes all neuron state
cfg_we  in  1  config write strobe
cfg_addr  in  clog2(N*N+N)  config address
cfg_data  in  8  config data (low W_WIDTH/V_WIDTH bits used)
mon_sel  in  clog2(N)  neuron index for membrane monitor
spike_out  out  N  registered per-neuron spike pulses
spike_any  out  1  registered OR of the spike_out next-state
spike_count  out  8  saturating count of cycles with spike_any
mon_v  out  V_WIDTH  membrane potential of neuron mon_sel (combinational mux of registers)

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high (port reset).
- Reset values: all v=0, refractory counters=0, spike_out=0, spike_any=0, spike_count=0, weights=0, biases=BIAS_INIT. Reset mid-operation overrides enable and cfg_we in the same edge.
- Config map: addr < N*N -> weight w[src=addr/N][dst=addr%N]; N*N <= addr < N*N+N -> bias[addr-N*N]; other addresses ignored. Diagonal weights are stored but never applied. Writes occur regardless of enable. A written value is used from the next edge onward.
- Per enabled edge, for each neuron i with refractory counter r_i==0:
  acc = v_i - (v_i >> LEAK_SHIFT) + bias_i + sum over j!=i of (spike_out[j] ? w[j][i] : 0). Compute acc in a signed accumulator wide enough (V_WIDTH+W_WIDTH+clog2(N)+2 bits) that no intermediate overflows.
  - If acc >= THRESHOLD: v_i <= 0, spike_out[i] <= 1, r_i <= REFRACT.
  - Otherwise: v_i <= clamp(acc, 0, 2^V_WIDTH-1), spike_out[i] <= 0.
- Refractory (r_i>0, enabled): v_i held 0, incoming spikes and bias ignored, r_i decrements, spike_out[i] <= 0.
- Spike_out is a one-cycle pulse. Synaptic latency is exactly one cycle: a spike registered at edge t contributes at edge t+1.
- enable low: v, r and spike_out hold. spike_any and spike_count do not update.
- spike_any <= OR of the spike_out next-state (aligned with spike_out). spike_count increments on each enabled edge where that OR is 1, and saturates at 255.
- Simultaneous spikes from several sources sum in the same cycle. Simultaneous firing of coupled neurons is legal.

Decomposition:
- Package lif_net_pkg: address-map constants and function (weight base, bias base), clamp helper, accumulator width function.
- Sub-module lif_neuron holds one neuron (v, refractory counter, threshold/clamp logic). It takes a precomputed signed synaptic sum. The top holds the weight and bias register files, the synaptic summation, the config decode, and the spike_any/spike_count logic.

Test Plan:
(Defaults throughout.)
1. Reset with enable=1 and cfg_we pulses during reset -> all outputs 0, mon_v=0 for every mon_sel, config unchanged by the writes.
2. bias[0]=40 (cfg_addr 16), others 0, enable held -> neuron0 v sequence 40, 75, 106, 133, 157, 178, 196, then spike_out[0]=1 on 8th edge. Spikes recur every 12 edges; spike_count=3 after 32 edges.
3. Same setup, w[0][1]=127 (cfg_addr 1) -> mon_v(sel=1)=127 exactly one edge after each spike_out[0] pulse; neuron1 never within refractory when hit.
4. Inhibition: bias[1]=50 for 1 edge then 0, w[0][1]=-128 -> neuron1 v clamps to 0 after neuron0 spike (no wrap to 2^8-x).
5. Refractory and freeze: neuron1 spiking while neuron0 spike arrives during its refractory window -> v1 stays 0. Deassert enable for 5 edges -> all v, spike_out, spike_count held, then resume identically shifted by 5.
6. Saturation: bias[0..3]=255, w all 0 -> counter reaches 255 and stays. Out-of-range cfg_addr=20 write -> no register changes.
